// File: rtl/dot_frame_buffer.sv
// -----------------------------------------------------------------------------
// dot_frame_buffer
//
// Double-buffered 8x8 dot-matrix frame store. The writer fills the back bank.
// The scan controller reads rows from the front bank. A swap request exchanges
// the two banks at the next frame boundary, which is a read of row 7.
//
// Optional feature (macro DOT_FRAME_BUFFER_SCROLL_EN):
//   Adds horizontal scrolling. A frame counter counts frame boundaries. Every
//   SCROLL_FRAMES boundaries, a 3-bit column offset k advances modulo 8. Each
//   fetched row is returned rotated left by k.
//
// Parameters:
//   SCROLL_FRAMES  frame boundaries per scroll step (1..255), scroll build only
//
// Ports:
//   clk           system clock; all logic runs on its rising edge
//   reset         synchronous active-low reset
//   wr_en         write strobe into the back bank
//   wr_row        row index for the write
//   wr_data       column pattern; bit 7 = leftmost column, 1 = lit
//   swap_req      one-cycle request to swap banks at the next frame boundary
//   rd_en         row fetch strobe
//   rd_row        row index to fetch from the front bank
//   rd_data       registered row pattern (holds its value when no fetch occurs)
//   rd_valid      high in the cycle in which rd_data holds a fetch result
//   swap_pending  a swap has been requested and has not yet executed
//   frame_start   one-cycle pulse in the cycle after a swap executes
// -----------------------------------------------------------------------------
module dot_frame_buffer #(
   parameter int SCROLL_FRAMES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_data,
   input  logic       swap_req,
   input  logic       rd_en,
   input  logic [2:0] rd_row,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       swap_pending,
   output logic       frame_start
);

   if (SCROLL_FRAMES < 1 || SCROLL_FRAMES > 255) begin : g_bad_param
      $error("dot_frame_buffer: SCROLL_FRAMES must be in 1..255");
   end

   logic [7:0] r_bank [2][8];
   logic       r_front;
   logic       r_swap_pending;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;
   logic       r_frame_start;

   logic       w_boundary;
   logic       w_swap;
   logic [7:0] w_front_word;
   logic [7:0] w_rd_word;

`ifdef DOT_FRAME_BUFFER_SCROLL_EN
   logic [7:0]  r_frame_cnt;
   logic [2:0]  r_offset;
   logic [15:0] w_dbl;
`endif

   // NOTE: every signal written in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_boundary   = rd_en && (rd_row == 3'd7);
      // A request in the boundary cycle itself executes without ever pending.
      w_swap       = w_boundary && (r_swap_pending || swap_req);
      w_front_word = r_bank[r_front][rd_row];
      w_rd_word    = w_front_word;
`ifdef DOT_FRAME_BUFFER_SCROLL_EN
      // Rotate left by k: after the shift, the upper byte of the doubled word
      // holds the rotated pattern, so bit 7 takes bit 7-k.
      w_dbl     = {w_front_word, w_front_word} << r_offset;
      w_rd_word = w_dbl[15:8];
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then update together from values sampled before the edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the banks are reset on purpose. The first fetch after reset
         // must return zeros, so this storage is built from flops, not RAM.
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
               r_bank[b][r] <= 8'h00;
            end
         end
         r_front        <= 1'b0;
         r_swap_pending <= 1'b0;
         r_rd_data      <= 8'h00;
         r_rd_valid     <= 1'b0;
         r_frame_start  <= 1'b0;
`ifdef DOT_FRAME_BUFFER_SCROLL_EN
         r_frame_cnt    <= 8'h00;
         r_offset       <= 3'd0;
`endif
      end else begin
         // The write targets the back bank as it stands in this cycle. In a
         // swap cycle, that bank becomes the new front bank.
         if (wr_en) begin
            r_bank[~r_front][wr_row] <= wr_data;
         end

         if (rd_en) begin
            r_rd_data <= w_rd_word;
         end
         r_rd_valid    <= rd_en;
         r_frame_start <= w_swap;

         if (w_swap) begin
            r_front        <= ~r_front;
            r_swap_pending <= 1'b0;
         end else if (swap_req) begin
            r_swap_pending <= 1'b1;
         end

`ifdef DOT_FRAME_BUFFER_SCROLL_EN
         // The boundary read uses the old offset. The new offset applies from
         // the next fetch onwards.
         if (w_boundary) begin
            if (r_frame_cnt == 8'(SCROLL_FRAMES - 1)) begin
               r_frame_cnt <= 8'h00;
               r_offset    <= r_offset + 3'd1;
            end else begin
               r_frame_cnt <= r_frame_cnt + 8'd1;
            end
         end
`endif
      end
   end

   assign rd_data      = r_rd_data;
   assign rd_valid     = r_rd_valid;
   assign swap_pending = r_swap_pending;
   assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_dot_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_dot_frame_buffer
//
// Scoreboard bench for dot_frame_buffer.
//
// Each driven cycle is applied to a behavioural model of the frame buffer,
// which keeps two banks as arrays, a front index, a pending flag and a scroll
// offset. The model pushes the per-cycle control expectations and the fetched
// row data into queues. A negedge monitor pops these and compares them with
// the DUT outputs.
//
// The scroll checks run when DOT_FRAME_BUFFER_SCROLL_EN is defined.
// -----------------------------------------------------------------------------
module tb_dot_frame_buffer;

`ifdef DOT_FRAME_BUFFER_SCROLL_EN
   localparam int SF = 1;
`else
   localparam int SF = 4;
`endif

   bit         clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       swap_req;
   logic       rd_en;
   logic [2:0] rd_row;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       swap_pending;
   logic       frame_start;

   dot_frame_buffer #(.SCROLL_FRAMES(SF)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_row       (wr_row),
      .wr_data      (wr_data),
      .swap_req     (swap_req),
      .rd_en        (rd_en),
      .rd_row       (rd_row),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .swap_pending (swap_pending),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         v;
      bit         fs;
      bit         sp;
      logic [7:0] d;
   } ctrl_t;

   ctrl_t      ctrl_q [$];
   logic [7:0] rd_q   [$];

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_bank [2][8];
   int m_front;
   bit m_pending;
   int m_k;
   int m_cnt;
   int m_last;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rotl(input int d, input int k);
      return ((d << k) | (d >> (8 - k))) & 8'hFF;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 8; r++) m_bank[b][r] = 0;
      m_front   = 0;
      m_pending = 0;
      m_k       = 0;
      m_cnt     = 0;
      m_last    = 0;
   endtask

   // Drives one clock cycle and records what the model expects after the edge.
   task automatic cyc(input bit rst_n, input bit we, input int wrow, input int wd,
                      input bit sr, input bit re, input int rrow);
      ctrl_t e;
      bit    boundary;
      bit    swap;
      reset    = rst_n;
      wr_en    = we;
      wr_row   = 3'(wrow);
      wr_data  = 8'(wd);
      swap_req = sr;
      rd_en    = re;
      rd_row   = 3'(rrow);
      if (!rst_n) begin
         model_reset();
         e.v = 0; e.fs = 0; e.sp = 0; e.d = 8'h00;
      end else begin
         boundary = re && (rrow == 7);
         swap     = boundary && (m_pending || sr);
         if (re) begin
            m_last = rotl(m_bank[m_front][rrow], m_k);
            rd_q.push_back(8'(m_last));
         end
         if (we) m_bank[1 - m_front][wrow] = wd;
         if (swap) begin
            m_front   = 1 - m_front;
            m_pending = 0;
         end else if (sr) begin
            m_pending = 1;
         end
`ifdef DOT_FRAME_BUFFER_SCROLL_EN
         if (boundary) begin
            m_cnt++;
            if (m_cnt == SF) begin
               m_cnt = 0;
               m_k   = (m_k + 1) % 8;
            end
         end
`endif
         e.v = re; e.fs = swap; e.sp = m_pending; e.d = 8'(m_last);
      end
      ctrl_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic sweep(input bit sr_first);
      for (int r = 0; r < 8; r++) cyc(1, 0, 0, 0, (r == 0) && sr_first, 1, r);
   endtask

   // Monitor: one control expectation per cycle, one data expectation per fetch
   always @(negedge clk) begin
      ctrl_t e;
      if (ctrl_q.size() > 0) begin
         e = ctrl_q.pop_front();
         check("rd_valid", {7'd0, rd_valid}, {7'd0, e.v});
         check("frame_start", {7'd0, frame_start}, {7'd0, e.fs});
         check("swap_pending", {7'd0, swap_pending}, {7'd0, e.sp});
         if (!e.v) check("rd_data_hold", rd_data, e.d);
         if (rd_valid === 1'b1) begin
            if (rd_q.size() == 0) check("rd_data_unexpected", 8'h01, 8'h00);
            else check("rd_data", rd_data, rd_q.pop_front());
         end
      end
   end

   initial begin
      automatic int pat [8] = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};
      model_reset();

      // Reset, then a sweep of the empty front bank: zeros, no frame_start
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      sweep(0);
      idle();

      // Load the back bank, request a swap, then sweep twice
      for (int r = 0; r < 8; r++) cyc(1, 1, r, pat[r], 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0);
      sweep(0);
      sweep(0);
      idle();

      // Swap request in the boundary cycle itself; no pending phase
      for (int r = 0; r < 8; r++) cyc(1, 1, r, 8'hA0 + r, 0, 0, 0);
      for (int r = 0; r < 7; r++) cyc(1, 0, 0, 0, 0, 1, r);
      cyc(1, 0, 0, 0, 1, 1, 7);
      sweep(0);

      // Two requests in one frame give one swap; a write in the swap cycle
      // lands in the new front bank
      cyc(1, 1, 2, 8'h5A, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 1, 1, 2);
      for (int r = 3; r < 7; r++) cyc(1, 0, 0, 0, 0, 1, r);
      cyc(1, 1, 5, 8'hE7, 0, 1, 7);
      sweep(0);
      sweep(0);

      // Reset mid-frame with a swap pending
      cyc(1, 0, 0, 0, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 1, 2);
      cyc(1, 0, 0, 0, 0, 1, 3);
      sweep(0);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 63) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 255), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) != 0), $urandom_range(0, 7));
      end

`ifdef DOT_FRAME_BUFFER_SCROLL_EN
      // A single lit dot in row 0 walks through all eight columns and wraps
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 8'h80, 1, 0, 0);
      sweep(0);
      for (int f = 0; f < 9; f++) sweep(0);
`endif

      idle();
      idle();
      repeat (3) @(negedge clk);
      check("ctrl_q_drained", 8'(ctrl_q.size()), 8'h00);
      check("rd_q_drained", 8'(rd_q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
